// File: rtl/mmio_event_fifo_if.sv
// Bus and producer signals for mmio_event_fifo: the MIPS data-bus slice
// (address/store data/strobes/load data) and the valid/ready push port.
interface mmio_event_fifo_if;
    logic [31:0] address;
    logic [31:0] data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] rd_data;
    logic        FifoAddress;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;

    modport master (
        output address, data, MemRead, MemWrite, in_valid, in_data,
        input  rd_data, FifoAddress, in_ready
    );

    modport slave (
        input  address, data, MemRead, MemWrite, in_valid, in_data,
        output rd_data, FifoAddress, in_ready
    );
endinterface

// File: rtl/mmio_event_fifo.sv
// Memory-mapped event queue: producer pushes via valid/ready, CPU pops DATA,
// reads STATUS, configures CTRL; level interrupt when count reaches threshold.
module mmio_event_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter logic [31:0] BASE  = 32'hFFFF0070
) (
    input  logic             clk,
    input  logic             reset,
    output logic             FifoInterrupt,
    mmio_event_fifo_if.slave bus
);
    localparam int unsigned   AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW         = AW + 1;
    localparam logic [31:0]   ADDR_DATA  = BASE;
    localparam logic [31:0]   ADDR_STAT  = BASE + 32'd4;
    localparam logic [31:0]   ADDR_CTRL  = BASE + 32'd8;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    ovf_q, ovf_d;
    logic [7:0]    thr_q, thr_d;
    logic          irq_en_q, irq_en_d;
    logic          hit_data, hit_stat, hit_ctrl;
    logic          empty, full, push, pop;
    logic          unused_data_bits;

    assign hit_data = (bus.address == ADDR_DATA);
    assign hit_stat = (bus.address == ADDR_STAT);
    assign hit_ctrl = (bus.address == ADDR_CTRL);
    assign bus.FifoAddress = hit_data | hit_stat | hit_ctrl;

    assign empty        = (count_q == '0);
    assign full         = (count_q == FULL_COUNT);
    assign bus.in_ready = !full;
    assign push         = bus.in_valid && !full;
    assign pop          = bus.MemRead && hit_data && !empty;

    assign unused_data_bits = ^{bus.data[31:16], bus.data[7:1]};

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        thr_d    = thr_q;
        irq_en_d = irq_en_q;

        if (push) tail_d = tail_q + AW'(1);
        if (pop)  head_d = head_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A STATUS store clears the counter even if an overflow lands this cycle.
        if (bus.MemWrite && hit_stat)
            ovf_d = '0;
        else if (bus.in_valid && full && (ovf_q != '1))
            ovf_d = ovf_q + 8'd1;

        if (bus.MemWrite && hit_ctrl) begin
            irq_en_d = bus.data[0];
            thr_d    = bus.data[15:8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
            thr_q    <= 8'd1;
            irq_en_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            thr_q    <= thr_d;
            irq_en_q <= irq_en_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= bus.in_data;
    end

    always_comb begin
        bus.rd_data = '0;
        if (hit_data && !empty)
            bus.rd_data = mem_q[head_q];
        else if (hit_stat)
            bus.rd_data = {ovf_q, 6'b0, full, empty, 16'(count_q)};
        else if (hit_ctrl)
            bus.rd_data = {16'b0, thr_q, 7'b0, irq_en_q};
    end

    assign FifoInterrupt = irq_en_q && (thr_q != '0) && (16'(count_q) >= 16'(thr_q));
endmodule

// File: tb/tb_mmio_event_fifo.sv
// Directed bench for mmio_event_fifo: vector table plus hand-written
// sequences for wrap-around, push+pop, interrupt and mid-cycle reset.
module tb_mmio_event_fifo;
    localparam logic [31:0] A_DATA = 32'hFFFF0070;
    localparam logic [31:0] A_STAT = 32'hFFFF0074;
    localparam logic [31:0] A_CTRL = 32'hFFFF0078;
    localparam logic [31:0] A_NONE = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic FifoInterrupt;
    int   total = 0;
    int   bad = 0;

    mmio_event_fifo_if bus ();

    mmio_event_fifo #(.DEPTH(8), .BASE(32'hFFFF0070)) dut (
        .clk          (clk),
        .reset        (reset),
        .FifoInterrupt(FifoInterrupt),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic        iv;
        logic [31:0] idata;
        logic [31:0] exp_rd;
        logic        exp_rdy;
        logic        exp_irq;
        logic        exp_fa;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(string nm, logic [31:0] a, logic r, logic w, logic [31:0] wd,
                                logic iv, logic [31:0] id, logic [31:0] er, logic erdy,
                                logic eirq, logic efa);
        vec_t v;
        v.nm = nm; v.addr = a; v.rd = r; v.wr = w; v.wdata = wd; v.iv = iv; v.idata = id;
        v.exp_rd = er; v.exp_rdy = erdy; v.exp_irq = eirq; v.exp_fa = efa;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // One bus cycle: inputs applied just after the edge, outputs sampled at negedge.
    task automatic drive(input logic [31:0] a, input logic r, input logic w,
                         input logic [31:0] wd, input logic iv, input logic [31:0] id);
        @(posedge clk);
        #1;
        bus.address = a; bus.MemRead = r; bus.MemWrite = w; bus.data = wd;
        bus.in_valid = iv; bus.in_data = id;
        @(negedge clk);
    endtask

    task automatic push_w(input logic [31:0] d);
        drive(A_NONE, 1'b0, 1'b0, '0, 1'b1, d);
        chk("push_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic pop_chk(input string nm, input logic [31:0] exp);
        drive(A_DATA, 1'b1, 1'b0, '0, 1'b0, '0);
        chk(nm, bus.rd_data, exp);
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        drive(a, 1'b1, 1'b0, '0, 1'b0, '0);
        chk(nm, bus.rd_data, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        drive(a, 1'b0, 1'b1, v, 1'b0, '0);
    endtask

    task automatic irq_chk(input string nm, input logic exp);
        drive(A_NONE, 1'b0, 1'b0, '0, 1'b0, '0);
        chk(nm, 32'(FifoInterrupt), 32'(exp));
    endtask

    initial begin
        bus.address = '0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.data = '0;
        bus.in_valid = 1'b0; bus.in_data = '0;

        vt.push_back(mk("rst_status", A_STAT, 1, 0, 0, 0, 0, 32'h0001_0000, 1, 0, 1));
        vt.push_back(mk("rst_ctrl",   A_CTRL, 1, 0, 0, 0, 0, 32'h0000_0100, 1, 0, 1));
        for (int k = 0; k < 8; k++)
            vt.push_back(mk("fill_status", A_STAT, 1, 0, 0, 1, 32'hA0 + 32'(k),
                            (k == 0) ? 32'h0001_0000 : 32'(k), 1, 0, 1));
        vt.push_back(mk("full_ovf0", A_STAT, 1, 0, 0, 1, 32'h55, 32'h0002_0008, 0, 0, 1));
        vt.push_back(mk("full_ovf1", A_STAT, 1, 0, 0, 1, 32'h55, 32'h0102_0008, 0, 0, 1));
        vt.push_back(mk("full_ovf2", A_STAT, 1, 0, 0, 1, 32'h55, 32'h0202_0008, 0, 0, 1));
        vt.push_back(mk("full_ovf3", A_STAT, 1, 0, 0, 0, 0,     32'h0302_0008, 0, 0, 1));
        vt.push_back(mk("ovf_clear", A_STAT, 0, 1, 32'hFFFF_FFFF, 1, 32'h55, 32'h0302_0008, 0, 0, 1));
        vt.push_back(mk("ovf_zero",  A_STAT, 1, 0, 0, 0, 0, 32'h0002_0008, 0, 0, 1));
        for (int k = 0; k < 8; k++)
            vt.push_back(mk("pop_order", A_DATA, 1, 0, 0, 0, 0, 32'hA0 + 32'(k),
                            (k != 0), 0, 1));
        vt.push_back(mk("drained",     A_STAT, 1, 0, 0, 0, 0, 32'h0001_0000, 1, 0, 1));
        vt.push_back(mk("empty_pop",   A_DATA, 1, 0, 0, 0, 0, 32'h0, 1, 0, 1));
        vt.push_back(mk("empty_still", A_STAT, 1, 0, 0, 0, 0, 32'h0001_0000, 1, 0, 1));
        vt.push_back(mk("data_store",  A_DATA, 0, 1, 32'h123, 0, 0, 32'h0, 1, 0, 1));
        vt.push_back(mk("store_ign",   A_STAT, 1, 0, 0, 0, 0, 32'h0001_0000, 1, 0, 1));
        vt.push_back(mk("misalign",    A_DATA + 32'd1, 1, 0, 0, 0, 0, 32'h0, 1, 0, 0));
        vt.push_back(mk("other_addr",  32'h1000_0000, 1, 0, 0, 0, 0, 32'h0, 1, 0, 0));
        vt.push_back(mk("ctrl_store",  A_CTRL, 0, 1, 32'hFFFF_FFFF, 0, 0, 32'h0000_0100, 1, 0, 1));
        vt.push_back(mk("ctrl_mask",   A_CTRL, 1, 0, 0, 0, 0, 32'h0000_FF01, 1, 0, 1));

        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        foreach (vt[i]) begin
            drive(vt[i].addr, vt[i].rd, vt[i].wr, vt[i].wdata, vt[i].iv, vt[i].idata);
            chk({vt[i].nm, ".rd"},  bus.rd_data, vt[i].exp_rd);
            chk({vt[i].nm, ".rdy"}, 32'(bus.in_ready), 32'(vt[i].exp_rdy));
            chk({vt[i].nm, ".irq"}, 32'(FifoInterrupt), 32'(vt[i].exp_irq));
            chk({vt[i].nm, ".fa"},  32'(bus.FifoAddress), 32'(vt[i].exp_fa));
        end

        // Wrap-around: tail passes index 7 on the second batch.
        for (int k = 0; k < 6; k++) push_w(32'hB0 + 32'(k));
        for (int k = 0; k < 6; k++) pop_chk("wrap_pop1", 32'hB0 + 32'(k));
        for (int k = 0; k < 5; k++) push_w(32'hC0 + 32'(k));
        rd_chk("wrap_count", A_STAT, 32'h0000_0005);
        for (int k = 0; k < 5; k++) pop_chk("wrap_pop2", 32'hC0 + 32'(k));
        rd_chk("wrap_empty", A_STAT, 32'h0001_0000);

        // Simultaneous push and pop at count 3.
        for (int k = 0; k < 3; k++) push_w(32'hD0 + 32'(k));
        drive(A_DATA, 1'b1, 1'b0, '0, 1'b1, 32'hD3);
        chk("simul_rd", bus.rd_data, 32'hD0);
        chk("simul_rdy", 32'(bus.in_ready), 32'd1);
        rd_chk("simul_count", A_STAT, 32'h0000_0003);
        for (int k = 1; k < 4; k++) pop_chk("simul_pop", 32'hD0 + 32'(k));

        // Interrupt at threshold 3.
        wr(A_CTRL, 32'h0000_0301);
        rd_chk("irq_ctrl", A_CTRL, 32'h0000_0301);
        for (int k = 0; k < 3; k++) begin
            push_w(32'hE0 + 32'(k));
            chk("irq_pre", 32'(FifoInterrupt), 32'd0);
        end
        irq_chk("irq_high", 1'b1);
        pop_chk("irq_pop", 32'hE0);
        chk("irq_popcyc", 32'(FifoInterrupt), 32'd1);
        irq_chk("irq_low", 1'b0);
        pop_chk("irq_pop2", 32'hE1);
        pop_chk("irq_pop3", 32'hE2);
        wr(A_CTRL, 32'h0000_0001);
        for (int k = 0; k < 3; k++) push_w(32'hF0 + 32'(k));
        irq_chk("irq_thr0", 1'b0);
        wr(A_CTRL, 32'h0000_0901);
        for (int k = 3; k < 8; k++) push_w(32'hF0 + 32'(k));
        irq_chk("irq_thr9", 1'b0);
        rd_chk("irq_full", A_STAT, 32'h0002_0008);

        // Mid-cycle reset with push and pop both active.
        drive(A_NONE, 1'b0, 1'b0, '0, 1'b1, 32'h66);
        pop_chk("pre_rst_pop", 32'hF0);
        pop_chk("pre_rst_pop", 32'hF1);
        rd_chk("pre_rst_stat", A_STAT, 32'h0100_0006);
        @(posedge clk);
        #1;
        bus.address = A_DATA; bus.MemRead = 1'b1; bus.MemWrite = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'hDEAD;
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        bus.MemRead = 1'b0; bus.in_valid = 1'b0; bus.address = A_NONE;
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_irq", 32'(FifoInterrupt), 32'd0);
        reset = 1'b1;
        rd_chk("post_rst_stat", A_STAT, 32'h0001_0000);
        rd_chk("post_rst_ctrl", A_CTRL, 32'h0000_0100);
        rd_chk("post_rst_data", A_DATA, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mmio_event_fifo.md
# mmio_event_fifo

Memory-mapped, interrupt-capable event queue on the single-cycle MIPS data bus, alongside `data_mem` and the timer. An external producer pushes 32-bit words through a valid/ready port. The processor pops those words and reads status through loads, and configures the block through stores. A level interrupt line feeds a cp0 interrupt input, the same way the timer interrupt does. Like the timer's address-hit signal, `FifoAddress` gates `data_mem` read/write enables off for this block's addresses.

## Interface
- `DEPTH`, 8: number of entries; power of two, 2..256.
- `BASE`, 32'hFFFF0070: word address of the DATA register; STATUS is at BASE+4 and CTRL at BASE+8.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (low = reset).
- `FifoInterrupt`  out  1  level interrupt request to cp0.
- `rd_data`  out  32  load data for this block's addresses.
- `FifoAddress`  out  1  high when `address` hits DATA, STATUS or CTRL.
- `address`  in  32  ALU output, the effective address.
- `data`  in  32  store data (rt value).
- `MemRead`  in  1  load in progress.
- `MemWrite`  in  1  store in progress.
- `in_valid`  in  1  producer has a word.
- `in_data`  in  32  producer word.
- `in_ready`  out  1  FIFO can accept a word.

## Operation
- **Storage:** circular buffer with `DEPTH` x 32-bit entries.
  - Head and tail pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0.
  - `count` is log2(DEPTH)+1 bits wide and ranges 0..DEPTH.
  - `empty` = (count==0); `full` = (count==DEPTH).
- **Address decode:** `FifoAddress` is combinational and asserted for exactly the three addresses, independent of `MemRead`/`MemWrite`.
  - Only an exact address match counts; bits [1:0] are not ignored.
- **DATA (BASE) read:** `rd_data` = head entry, or 0 when empty.
  - A pop occurs at the clock edge when `MemRead` is high, the address is DATA and the FIFO is not empty.
  - A load from DATA while empty returns 0 and leaves all state unchanged.
  - Stores to DATA are ignored.
- **STATUS (BASE+4) read:**
  - [15:0] = count, zero-extended.
  - [16] = empty.
  - [17] = full.
  - [23:18] = 0.
  - [31:24] = overflow counter.
- **STATUS write:** any `MemWrite` to STATUS clears the overflow counter to 0; the store data is ignored.
- **CTRL (BASE+8):** read/write register.
  - [0] = irq_enable.
  - [15:8] = threshold.
  - All other bits read as 0; writes to them are discarded.
- **`rd_data` for other addresses:** 0. `rd_data` is purely combinational from address and state.
- **Push:** `in_ready` = !full, computed from registered state only (no combinational path from the pop).
  - A word is pushed when `in_valid && in_ready`; `in_data` is written at the tail and the tail advances.
- **Overflow:** `in_valid && !in_ready` increments the overflow counter by 1 per cycle, saturating at 255.
  - If a clearing write to STATUS occurs in the same cycle, the clear wins and the counter becomes 0.
- **Simultaneous push and pop** (only possible when 0 < count < DEPTH): both pointers advance and count is unchanged.
  - The popped word is the pre-edge head.
- **Interrupt:** `FifoInterrupt` = irq_enable && (threshold != 0) && (count >= threshold). The comparison is zero-extended to 16 bits.
  - It is level-sensitive and combinational from registers; it drops only when pops reduce count, or when CTRL is rewritten.
  - A threshold greater than DEPTH never fires.

## Timing
- **Reset (asynchronous, while `reset` is low):**
  - Pointers, count and overflow counter = 0; irq_enable = 0; threshold = 1.
  - Consequently `in_ready` = 1, `FifoInterrupt` = 0, and a DATA read returns 0. Storage contents are don't-care.
- **Reset asserted mid-transaction:** any push or pop in that cycle is discarded; the state is exactly the reset state.
- **Push latency:** a word pushed at edge N is visible on a DATA read, and counted in STATUS, in the cycle after edge N.
- **Load/pop timing:** a DATA load returns its data in the same cycle (single-cycle machine); the pop commits at the end of that cycle.
- **Interrupt timing:**
  - `FifoInterrupt` updates in the cycle after the edge that changes count or CTRL.
  - A push that reaches the threshold at edge N asserts `FifoInterrupt` during cycle N+1.
- **Store timing:** stores to CTRL/STATUS take effect at the store's edge.
- **No wait states:** `in_ready` never depends on `in_valid`.

## Test plan
- **Reset defaults:** hold `reset`=0 for 2 cycles, release, load STATUS -> 32'h0001_0000; load CTRL -> 32'h0000_0100; `in_ready`=1; `FifoInterrupt`=0.
- **Fill to full:** push 8 words 0xA0..0xA7 -> STATUS = 32'h0002_0008, `in_ready`=0. Drive `in_valid` for 3 more cycles -> STATUS[31:24]=3. Store to STATUS -> overflow counter 0. Pop 8 times -> 0xA0..0xA7 in order, then STATUS = 32'h0001_0000.
- **Wrap-around:** push 6, pop 6, push 5 -> pops return the last 5 words in order (tail wraps past index 7); count reaches 0.
- **Simultaneous push and pop:** with count=3, push and pop in the same cycle -> count stays 3 and the popped word is the oldest entry.
- **Interrupt:** store CTRL = 32'h0000_0301 (threshold 3, enabled), push 3 -> `FifoInterrupt` high in the cycle after the third push; one pop -> low in the next cycle. With threshold=0, pushes never raise the interrupt.
- **Empty pop and mid-operation reset:** DATA load when empty -> 0 and no state change. Assert `reset` during a cycle with a push and a pop -> all counters 0 and CTRL back to its reset value.
